// File: rtl/chaos_pkg.sv
// chaos_pkg: shared state encoding and word geometry for the chaos config loader
package chaos_pkg;
  localparam int WORD_W = 32;
  localparam int LEN_W = $clog2(WORD_W + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;
endpackage

// File: rtl/chaos_shift_word.sv
// chaos_shift_word: parallel-load/serial-out word register with serial readback capture
module chaos_shift_word
  import chaos_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              emit,
  input  logic [LEN_W-1:0]  len,
  input  logic [WORD_W-1:0] din,
  input  logic              sin,
  output logic              sout,
  output logic              last,
  output logic [WORD_W-1:0] rdata,
  output logic              rdata_valid
);
  logic [WORD_W-1:0] sr, cap_nxt;
  logic [WORD_W-2:0] cap;
  logic [LEN_W-1:0] cnt, len_q;
  assign cap_nxt = {sin, cap};
  assign sout = sr[0];
  assign last = cnt == LEN_W'(1);
  // readback enters at the MSB, so a short word is shifted down to right-justify it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      cap <= '0;
      cnt <= '0;
      len_q <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= emit;
      if (emit) rdata <= cap_nxt >> (LEN_W'(WORD_W) - len_q);
      if (load) begin
        sr <= din;
        cap <= '0;
        cnt <= len;
        len_q <= len;
      end else if (shift) begin
        sr <= sr >> 1;
        cap <= cap_nxt[WORD_W-1:1];
        cnt <= cnt - LEN_W'(1);
      end
    end
endmodule

// File: rtl/chaos_config_loader.sv
// chaos_config_loader: streams 32-bit words into the cell configuration chain and latches it
module chaos_config_loader
  import chaos_pkg::*;
#(
  parameter int NCELLS = 400,
  parameter int CFGBITS = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic        abort,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic        shift_en,
  output logic        shift_data,
  input  logic        shift_rdata,
  output logic        latch,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        done
);
  localparam int TOTAL = NCELLS * CFGBITS;
  localparam int CW = $clog2(TOTAL + 1);
  logic [1:0] state, state_nxt;
  logic [CW-1:0] bits_sent;
  logic [31:0] rem;
  logic [LEN_W-1:0] len;
  logic hs, last, in_shift, sout;
  assign in_shift = state == S_SHIFT;
  assign rem = 32'(TOTAL) - 32'(bits_sent);
  assign len = rem >= 32'(WORD_W) ? LEN_W'(WORD_W) : rem[LEN_W-1:0];
  assign word_ready = state == S_FETCH && !abort;
  assign hs = word_ready && word_valid;
  assign shift_en = in_shift;
  assign shift_data = in_shift && sout;
  assign latch = state == S_LATCH;
  assign done = state == S_LATCH;
  assign busy = state != S_IDLE;
  // bits_sent already includes the word being shifted, so its end decides FETCH vs LATCH
  always_comb
    state_nxt = abort && busy ? S_IDLE :
                state == S_IDLE ? (start ? S_FETCH : S_IDLE) :
                state == S_FETCH ? (word_valid ? S_SHIFT : S_FETCH) :
                state == S_SHIFT ? (last ? (bits_sent == CW'(TOTAL) ? S_LATCH : S_FETCH) : S_SHIFT) :
                S_IDLE;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= S_IDLE;
      bits_sent <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) bits_sent <= '0;
      else if (hs) bits_sent <= bits_sent + CW'(len);
    end
  chaos_shift_word u_word (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .load(hs),
    .shift(in_shift),
    .emit(in_shift && last && !abort),
    .len(len),
    .din(word_data),
    .sin(shift_rdata),
    .sout(sout),
    .last(last),
    .rdata(rdata),
    .rdata_valid(rdata_valid)
  );
endmodule
